// File: rtl/rs_wakeup_queue.sv
// Age-ordered reservation station with multi-port tag wakeup, dispatch bypass and flush.
// Define RS_ISSUE_REG_EN to register the select result before it drives the issue port.
module rs_wakeup_queue #(
  parameter int DEPTH     = 8,
  parameter int TAG_W     = 6,
  parameter int ROB_W     = 6,
  parameter int PAYLOAD_W = 72,
  parameter int NUM_WB    = 2,
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int IDX_W    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  logic [PAYLOAD_W-1:0]    disp_payload,
  input  logic [TAG_W-1:0]        disp_src1_tag,
  input  logic [TAG_W-1:0]        disp_src2_tag,
  input  logic                    disp_src1_rdy,
  input  logic                    disp_src2_rdy,
  input  logic [TAG_W-1:0]        disp_dst_tag,
  input  logic [ROB_W-1:0]        disp_rob_tag,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*TAG_W-1:0] wb_tag,
  output logic                    issue_valid,
  input  logic                    issue_ready,
  output logic [PAYLOAD_W-1:0]    issue_payload,
  output logic [TAG_W-1:0]        issue_src1_tag,
  output logic [TAG_W-1:0]        issue_src2_tag,
  output logic [TAG_W-1:0]        issue_dst_tag,
  output logic [ROB_W-1:0]        issue_rob_tag,
  output logic [CNT_W-1:0]        count
);

  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     src1_rdy_q;
  logic [DEPTH-1:0]     src2_rdy_q;
  logic [TAG_W-1:0]     src1_tag_q [DEPTH];
  logic [TAG_W-1:0]     src2_tag_q [DEPTH];
  logic [TAG_W-1:0]     dst_tag_q  [DEPTH];
  logic [ROB_W-1:0]     rob_tag_q  [DEPTH];
  logic [PAYLOAD_W-1:0] payload_q  [DEPTH];
  // age_q[i][j] set means entry i is older than entry j
  logic [DEPTH-1:0]     age_q      [DEPTH];

  logic [DEPTH-1:0]     cand;
  logic [DEPTH-1:0]     sel;
  logic                 sel_any;
  logic [PAYLOAD_W-1:0] sel_payload;
  logic [TAG_W-1:0]     sel_src1_tag;
  logic [TAG_W-1:0]     sel_src2_tag;
  logic [TAG_W-1:0]     sel_dst_tag;
  logic [ROB_W-1:0]     sel_rob_tag;
  logic [IDX_W-1:0]     alloc_idx;
  logic                 accept;
  logic                 take;
  logic                 dec;
  logic [CNT_W-1:0]     count_nxt;

  function automatic logic wb_hit(input logic [TAG_W-1:0] tag,
                                  input logic [NUM_WB-1:0] v,
                                  input logic [NUM_WB*TAG_W-1:0] t);
    wb_hit = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (v[p] && (t[p*TAG_W +: TAG_W] == tag)) wb_hit = 1'b1;
    end
  endfunction

  assign disp_ready = (count != CNT_W'(DEPTH));
  assign accept     = disp_valid && disp_ready && !flush;

  // Oldest ready entry: a candidate with no other candidate older than it.
  always_comb begin
    cand = '0;
    sel  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cand[i] = valid_q[i] && src1_rdy_q[i] && src2_rdy_q[i];
    end
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = cand[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && cand[j] && age_q[j][i]) sel[i] = 1'b0;
      end
    end
  end

  assign sel_any = |cand;

  always_comb begin
    sel_payload  = '0;
    sel_src1_tag = '0;
    sel_src2_tag = '0;
    sel_dst_tag  = '0;
    sel_rob_tag  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        sel_payload  = sel_payload  | payload_q[i];
        sel_src1_tag = sel_src1_tag | src1_tag_q[i];
        sel_src2_tag = sel_src2_tag | src2_tag_q[i];
        sel_dst_tag  = sel_dst_tag  | dst_tag_q[i];
        sel_rob_tag  = sel_rob_tag  | rob_tag_q[i];
      end
    end
  end

  // Slot being freed this cycle still reads valid, so it is not reused until next cycle.
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
  end

`ifdef RS_ISSUE_REG_EN
  logic                 oreg_valid;
  logic [PAYLOAD_W-1:0] oreg_payload;
  logic [TAG_W-1:0]     oreg_src1_tag;
  logic [TAG_W-1:0]     oreg_src2_tag;
  logic [TAG_W-1:0]     oreg_dst_tag;
  logic [ROB_W-1:0]     oreg_rob_tag;

  assign take = sel_any && (!oreg_valid || issue_ready);
  assign dec  = oreg_valid && issue_ready;

  assign issue_valid    = oreg_valid;
  assign issue_payload  = oreg_payload;
  assign issue_src1_tag = oreg_src1_tag;
  assign issue_src2_tag = oreg_src2_tag;
  assign issue_dst_tag  = oreg_dst_tag;
  assign issue_rob_tag  = oreg_rob_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oreg_valid    <= 1'b0;
      oreg_payload  <= '0;
      oreg_src1_tag <= '0;
      oreg_src2_tag <= '0;
      oreg_dst_tag  <= '0;
      oreg_rob_tag  <= '0;
    end else if (flush) begin
      oreg_valid    <= 1'b0;
      oreg_payload  <= '0;
      oreg_src1_tag <= '0;
      oreg_src2_tag <= '0;
      oreg_dst_tag  <= '0;
      oreg_rob_tag  <= '0;
    end else if (take) begin
      oreg_valid    <= 1'b1;
      oreg_payload  <= sel_payload;
      oreg_src1_tag <= sel_src1_tag;
      oreg_src2_tag <= sel_src2_tag;
      oreg_dst_tag  <= sel_dst_tag;
      oreg_rob_tag  <= sel_rob_tag;
    end else if (dec) begin
      oreg_valid    <= 1'b0;
    end
  end
`else
  assign take = sel_any && issue_ready;
  assign dec  = take;

  assign issue_valid    = sel_any;
  assign issue_payload  = sel_payload;
  assign issue_src1_tag = sel_src1_tag;
  assign issue_src2_tag = sel_src2_tag;
  assign issue_dst_tag  = sel_dst_tag;
  assign issue_rob_tag  = sel_rob_tag;
`endif

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (accept && !dec) begin
      count_nxt = count + CNT_W'(1);
    end else if (!accept && dec) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Entry storage: wakeup snooping, release on issue or flush, and dispatch write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      src1_rdy_q <= '0;
      src2_rdy_q <= '0;
      count      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        src1_tag_q[i] <= '0;
        src2_tag_q[i] <= '0;
        dst_tag_q[i]  <= '0;
        rob_tag_q[i]  <= '0;
        payload_q[i]  <= '0;
        age_q[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && wb_hit(src1_tag_q[i], wb_valid, wb_tag)) src1_rdy_q[i] <= 1'b1;
        if (valid_q[i] && wb_hit(src2_tag_q[i], wb_valid, wb_tag)) src2_rdy_q[i] <= 1'b1;
        if (flush || (take && sel[i])) valid_q[i] <= 1'b0;
      end
      if (accept) begin
        valid_q[alloc_idx]    <= 1'b1;
        src1_tag_q[alloc_idx] <= disp_src1_tag;
        src2_tag_q[alloc_idx] <= disp_src2_tag;
        dst_tag_q[alloc_idx]  <= disp_dst_tag;
        rob_tag_q[alloc_idx]  <= disp_rob_tag;
        payload_q[alloc_idx]  <= disp_payload;
        src1_rdy_q[alloc_idx] <= disp_src1_rdy || (disp_src1_tag == '0) ||
                                 wb_hit(disp_src1_tag, wb_valid, wb_tag);
        src2_rdy_q[alloc_idx] <= disp_src2_rdy || (disp_src2_tag == '0) ||
                                 wb_hit(disp_src2_tag, wb_valid, wb_tag);
        age_q[alloc_idx]      <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          if (valid_q[j]) age_q[j][alloc_idx] <= 1'b1;
        end
      end
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_rs_wakeup_queue.sv
// Randomised bench for rs_wakeup_queue (default combinational-issue build) against an
// in-order list model: entries kept in dispatch order, oldest fully-ready one issues.
module tb_rs_wakeup_queue;

  localparam int DEPTH     = 8;
  localparam int TAG_W     = 6;
  localparam int ROB_W     = 6;
  localparam int PAYLOAD_W = 72;
  localparam int NUM_WB    = 2;
  localparam int CNT_W     = $clog2(DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    flush;
  logic                    disp_valid;
  logic                    disp_ready;
  logic [PAYLOAD_W-1:0]    disp_payload;
  logic [TAG_W-1:0]        disp_src1_tag;
  logic [TAG_W-1:0]        disp_src2_tag;
  logic                    disp_src1_rdy;
  logic                    disp_src2_rdy;
  logic [TAG_W-1:0]        disp_dst_tag;
  logic [ROB_W-1:0]        disp_rob_tag;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic                    issue_valid;
  logic                    issue_ready;
  logic [PAYLOAD_W-1:0]    issue_payload;
  logic [TAG_W-1:0]        issue_src1_tag;
  logic [TAG_W-1:0]        issue_src2_tag;
  logic [TAG_W-1:0]        issue_dst_tag;
  logic [ROB_W-1:0]        issue_rob_tag;
  logic [CNT_W-1:0]        count;

  always #5 clk = ~clk;

  rs_wakeup_queue #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W), .PAYLOAD_W(PAYLOAD_W), .NUM_WB(NUM_WB)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_dst_tag(disp_dst_tag), .disp_rob_tag(disp_rob_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_payload(issue_payload),
    .issue_src1_tag(issue_src1_tag), .issue_src2_tag(issue_src2_tag),
    .issue_dst_tag(issue_dst_tag), .issue_rob_tag(issue_rob_tag), .count(count)
  );

  typedef struct {
    logic [PAYLOAD_W-1:0] payload;
    logic [TAG_W-1:0]     s1;
    logic [TAG_W-1:0]     s2;
    logic [TAG_W-1:0]     dst;
    logic [ROB_W-1:0]     rob;
    bit                   r1;
    bit                   r2;
  } ent_t;

  ent_t mq[$];
  int   total = 0;
  int   bad   = 0;
  int   dst_seq = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit wbHit(input logic [TAG_W-1:0] t);
    bit h = 0;
    for (int p = 0; p < NUM_WB; p++)
      if (wb_valid[p] && wb_tag[p*TAG_W +: TAG_W] == t) h = 1;
    return h;
  endfunction

  task automatic setIdle();
    flush = 0; disp_valid = 0; issue_ready = 0; wb_valid = '0; wb_tag = '0;
    disp_src1_tag = '0; disp_src2_tag = '0; disp_src1_rdy = 0; disp_src2_rdy = 0;
    disp_dst_tag = '0; disp_rob_tag = '0; disp_payload = '0;
  endtask

  task automatic setDisp(input int t1, input bit r1, input int t2, input bit r2);
    disp_valid    = 1;
    disp_src1_tag = TAG_W'(t1);
    disp_src1_rdy = r1;
    disp_src2_tag = TAG_W'(t2);
    disp_src2_rdy = r2;
    dst_seq++;
    disp_dst_tag  = TAG_W'(dst_seq);
    disp_rob_tag  = ROB_W'($urandom());
    disp_payload  = {8'($urandom()), $urandom(), $urandom()};
  endtask

  // Inputs are set by the caller; this checks the DUT against the model in the
  // current cycle and then advances the model across the coming clock edge.
  task automatic applyStimulus();
    int   pick;
    bit   fire;
    bit   acc;
    ent_t e;
    #1;
    pick = -1;
    for (int k = 0; k < mq.size(); k++)
      if (mq[k].r1 && mq[k].r2) begin pick = k; break; end
    checkOutput("count", 128'(count), 128'(mq.size()));
    checkOutput("disp_ready", 128'(disp_ready), 128'(mq.size() != DEPTH));
    checkOutput("issue_valid", 128'(issue_valid), 128'(pick >= 0));
    if (pick >= 0) begin
      checkOutput("issue_payload", 128'(issue_payload), 128'(mq[pick].payload));
      checkOutput("issue_src1_tag", 128'(issue_src1_tag), 128'(mq[pick].s1));
      checkOutput("issue_src2_tag", 128'(issue_src2_tag), 128'(mq[pick].s2));
      checkOutput("issue_dst_tag", 128'(issue_dst_tag), 128'(mq[pick].dst));
      checkOutput("issue_rob_tag", 128'(issue_rob_tag), 128'(mq[pick].rob));
    end
    fire = (pick >= 0) && issue_ready;
    acc  = disp_valid && (mq.size() != DEPTH) && !flush;
    if (flush) begin
      mq.delete();
    end else begin
      if (fire) mq.delete(pick);
      for (int k = 0; k < mq.size(); k++) begin
        if (wbHit(mq[k].s1)) mq[k].r1 = 1;
        if (wbHit(mq[k].s2)) mq[k].r2 = 1;
      end
      if (acc) begin
        e.payload = disp_payload; e.s1 = disp_src1_tag; e.s2 = disp_src2_tag;
        e.dst = disp_dst_tag; e.rob = disp_rob_tag;
        e.r1 = disp_src1_rdy || disp_src1_tag == 0 || wbHit(disp_src1_tag);
        e.r2 = disp_src2_rdy || disp_src2_tag == 0 || wbHit(disp_src2_tag);
        mq.push_back(e);
      end
    end
    @(negedge clk);
    setIdle();
  endtask

  task automatic doReset();
    setIdle();
    reset = 1;
    #1;
    checkOutput("rst_issue_valid", 128'(issue_valid), 128'(0));
    checkOutput("rst_count", 128'(count), 128'(0));
    checkOutput("rst_disp_ready", 128'(disp_ready), 128'(1));
    checkOutput("rst_issue_payload", 128'(issue_payload), 128'(0));
    checkOutput("rst_issue_dst_tag", 128'(issue_dst_tag), 128'(0));
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic idleCycles(input int n, input bit ir);
    for (int k = 0; k < n; k++) begin
      issue_ready = ir;
      applyStimulus();
    end
  endtask

  initial begin
    reset = 1;
    setIdle();
    @(negedge clk);
    doReset();

    // simple ready op issues next cycle
    setDisp(5, 1, 0, 0); applyStimulus();
    idleCycles(2, 1);

    // wakeup on port 1 releases a waiting op one cycle later
    setDisp(9, 0, 0, 0); applyStimulus();
    idleCycles(3, 1);
    issue_ready = 1; wb_valid = 2'b10; wb_tag = {6'd9, 6'd0}; applyStimulus();
    idleCycles(2, 1);

    // dispatch bypass from a same-cycle writeback
    setDisp(12, 0, 0, 1); wb_valid = 2'b01; wb_tag = {6'd0, 6'd12}; applyStimulus();
    idleCycles(2, 1);

    // age order: A blocked, B and C ready
    setDisp(20, 0, 0, 1); applyStimulus();
    setDisp(0, 1, 0, 1);  applyStimulus();
    setDisp(3, 1, 4, 1);  applyStimulus();
    idleCycles(1, 0);
    idleCycles(3, 1);
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd20}; applyStimulus();
    idleCycles(2, 1);

    // fill to full, issue one, refill
    for (int k = 0; k < DEPTH + 2; k++) begin
      setDisp(0, 1, 0, 1); applyStimulus();
    end
    issue_ready = 1; setDisp(0, 1, 0, 1); applyStimulus();
    setDisp(7, 1, 0, 1); applyStimulus();
    idleCycles(DEPTH + 2, 1);

    // flush with five entries and a dispatch in flight
    for (int k = 0; k < 5; k++) begin
      setDisp(30, 0, 0, 1); applyStimulus();
    end
    flush = 1; setDisp(0, 1, 0, 1); applyStimulus();
    idleCycles(2, 1);

    // randomised traffic with one reset mid-stream
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc == 400) doReset();
      if ($urandom_range(0, 99) < 60)
        setDisp($urandom_range(0, 15), $urandom_range(0, 3) == 0,
                $urandom_range(0, 15), $urandom_range(0, 3) == 0);
      issue_ready = ($urandom_range(0, 99) < 55);
      wb_valid    = NUM_WB'($urandom());
      wb_tag      = {6'($urandom_range(1, 15)), 6'($urandom_range(1, 15))};
      flush       = ($urandom_range(0, 59) == 0);
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_wakeup_queue.md
# rs_wakeup_queue

Parametrised reservation station for the out-of-order core, sitting between dispatch and one functional-unit issue port. It holds up to DEPTH renamed micro-ops, snoops NUM_WB writeback tag buses to mark source operands ready, and issues the oldest fully-ready entry each cycle. It generalises the fixed single-bus, fixed-size RS entry to configurable depth, tag widths, opaque payload and multiple wakeup ports, and adds age-ordered select and flush.

## Interface
- DEPTH, 8: entry count, ≥2.
- TAG_W, 6: physical register tag width; tag 0 is x0, always ready.
- ROB_W, 6: ROB tag width.
- PAYLOAD_W, 72: opaque control payload (pc, imm, alu_op, alu_src, mem flags), passed through unmodified.
- NUM_WB, 2: writeback/wakeup ports.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  discard every entry (mispredict recovery).
- disp_valid / disp_ready  in/out  1  dispatch handshake.
- disp_payload  in  PAYLOAD_W  opaque control.
- disp_src1_tag, disp_src2_tag  in  TAG_W  physical sources.
- disp_src1_rdy, disp_src2_rdy  in  1  busy-table readiness at dispatch.
- disp_dst_tag  in  TAG_W; disp_rob_tag  in  ROB_W.
- wb_valid  in  NUM_WB  per-port tag broadcast valid.
- wb_tag  in  NUM_WB*TAG_W  port i at bits [i*TAG_W +: TAG_W].
- issue_valid / issue_ready  out/in  1  issue handshake.
- issue_payload  out  PAYLOAD_W; issue_src1_tag, issue_src2_tag, issue_dst_tag  out  TAG_W; issue_rob_tag  out  ROB_W.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Per entry: valid, src1_rdy, src2_rdy, tags, payload; plus DEPTH×DEPTH age matrix (row i bit j set = i older than j).
- Dispatch accepted when disp_valid && disp_ready && !flush; written into lowest-index free slot; age row set to 0 vs. nothing, column set: new entry younger than all valid entries.
- Source ready on write = disp_srcN_rdy OR tag==0 OR any wb_valid[i] with wb_tag[i]==tag in same cycle (dispatch bypass).
- Wakeup: every valid entry, each source, compared against all NUM_WB ports each cycle; match sets rdy bit at edge. Ready bits never clear.
- Select: candidates = valid && src1_rdy && src2_rdy; pick the one older than all other candidates. issue_valid = any candidate.
- Entry freed at edge when issue_valid && issue_ready; age bits of freed slot irrelevant (valid gates them).
- disp_ready = (count != DEPTH), registered state only; slot freed this cycle not reusable until next cycle.
- count increments on accept, decrements on issue, unchanged when both.
- flush: all valid cleared at edge; dispatch that cycle dropped; issue handshake that cycle still completes externally but entry is gone regardless.

## Timing
- Reset values: all valid 0, count 0, disp_ready 1, issue_valid 0, issue payload/tags 0.
- Dispatch-to-issue: entry with both sources ready issuable the cycle after acceptance (1 cycle min, base build).
- Wakeup-to-issue: wb tag at cycle N -> issue_valid at N+1.
- Issue outputs combinational from registered state (base build); stable while issue_valid && !issue_ready unless a strictly older entry becomes ready.
- Full: count==DEPTH -> disp_ready 0; simultaneous issue does not raise it that cycle.
- Reset mid-operation: all entries lost immediately, no issue.

## Configuration
- RS_ISSUE_REG_EN defined: select result loaded into an output register; issue_* driven from it; register refills when empty or consumed (issue_valid && issue_ready); entry freed when loaded into the register; flush clears register. Dispatch-to-issue latency 2, wakeup-to-issue 2. count includes the register occupant.
- Undefined: combinational issue as above.

## Test plan
- Reset then dispatch tag src1=5 rdy, src2=0 -> issue_valid next cycle, issue_dst_tag matches, count 1->0 after handshake.
- Dispatch src1=9 not ready; wb_valid[1]=1 wb_tag=9 at cycle 10 -> issue_valid at cycle 11, not before.
- Dispatch src=12 not ready in same cycle as wb_tag[0]=12 -> entry captured ready, issues next cycle.
- Dispatch A (blocked), B, C ready; wake A -> issue order B, C, then A; with B, C both ready, B (older) first.
- Fill DEPTH=8 entries -> disp_ready 0, count 8; issue one -> disp_ready 1 next cycle, new entry lands in freed slot.
- 5 entries valid, flush with disp_valid high -> count 0, issue_valid 0 next cycle, dispatched op absent.
